// File: rtl/fetch_instr_buf.sv
// Instruction buffer between the icache return path and decode: splits 8B fetch
// blocks into single-instruction entries of an in-order queue, flushed by nuke.
package fetch_instr_buf_pkg;
  typedef struct packed {
    logic valid;
  } t_nuke_pkt;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } t_instr_pkt;
endpackage

module fetch_instr_buf
  import fetch_instr_buf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  t_nuke_pkt                  nuke_rb1,
  input  logic                       resume_fetch_rbx,
  input  logic                       fb_valid_if2,
  input  logic [63:0]                fb_pc_if2,
  input  logic [63:0]                fb_data_if2,
  output logic                       fb_ready_if2,
  output logic                       valid_fe1,
  output t_instr_pkt                 instr_fe1,
  input  logic                       decode_ready_de0,
  output logic [$clog2(DEPTH+1)-1:0] occ_fe1
);
  // state | meaning
  // RUN   | normal push/pop operation
  // DRAIN | after nuke: queue empty, stale icache returns accepted and dropped
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} t_state;

  t_state            state_q, state_d;
  t_instr_pkt        mem_q [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic              nuke, run, pop, push_acc;
  logic [1:0]        npush;
  logic [OW-1:0]     free_slots;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign nuke = nuke_rb1.valid;
  assign run  = (state_q == RUN);

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (nuke) state_d = DRAIN;
      DRAIN:   if (resume_fetch_rbx && !nuke) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM: outputs; ready is derived from the registered count only
  always_comb begin
    free_slots   = OW'(DEPTH) - occ_q;
    fb_ready_if2 = !run || (free_slots >= OW'(2));
    valid_fe1    = run && (occ_q != '0) && !nuke;
    instr_fe1    = mem_q[head_q];
    occ_fe1      = occ_q;
  end

  assign pop      = valid_fe1 && decode_ready_de0;
  assign push_acc = run && fb_valid_if2 && fb_ready_if2 && !nuke;
  assign npush    = !push_acc ? 2'd0 : (fb_pc_if2[2] ? 2'd1 : 2'd2);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (nuke) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (pop) head_d = ptr_inc(head_q);
      if (npush == 2'd1) tail_d = ptr_inc(tail_q);
      else if (npush == 2'd2) tail_d = ptr_inc(ptr_inc(tail_q));
      occ_d = occ_q + OW'(npush) - OW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      if (push_acc) begin
        if (fb_pc_if2[2]) begin
          mem_q[tail_q] <= '{pc: fb_pc_if2, instr: fb_data_if2[63:32]};
        end else begin
          mem_q[tail_q]          <= '{pc: fb_pc_if2, instr: fb_data_if2[31:0]};
          mem_q[ptr_inc(tail_q)] <= '{pc: fb_pc_if2 + 64'd4, instr: fb_data_if2[63:32]};
        end
      end
    end
  end

  a_pc_align: assert property (@(posedge clk) disable iff (!reset_n)
    fb_valid_if2 |-> (fb_pc_if2[1:0] == 2'b00));
  a_occ_max: assert property (@(posedge clk) disable iff (!reset_n)
    occ_q <= OW'(DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    push_acc |-> (int'(occ_q) + int'(npush) <= DEPTH));
  a_stall_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (valid_fe1 && !decode_ready_de0) |=> $stable(instr_fe1));
endmodule
